// File: rtl/countdown_pkg.sv
// Shared types and constants for the packed-BCD countdown timer.
package countdown_pkg;

  // Timer state. RUN is the only state in which ticks are consumed.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // True when a nibble is a legal BCD digit (0..9).
  function automatic logic digit_ok(input logic [3:0] d);
    return d <= BCD_NINE;
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the decrement chain: subtracts the incoming borrow,
// wrapping 0 -> 9 and passing the borrow on to the next digit.
module bcd_digit_dec
  import countdown_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       borrow_in,
  output logic [3:0] digit_next,
  output logic       borrow_out
);

  // Subtract the borrow from this digit, wrapping through nine.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    digit_next = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == BCD_ZERO) begin
        digit_next = BCD_NINE;
        borrow_out = 1'b1;
      end else begin
        digit_next = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/countdown_bcd_timer.sv
// Packed-BCD countdown timer. Loaded with a start time, decrements once
// per tick while running, and reports warning, expiry and load errors.
// All outputs are registered.
module countdown_bcd_timer
  import countdown_pkg::*;
#(
  parameter int                      NUM_DIGITS = 4,
  parameter logic [4*NUM_DIGITS-1:0] WARN_BCD   = 16'h0010
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   load_value,
  input  logic                      start,
  input  logic                      pause,
  output logic [4*NUM_DIGITS-1:0]   count,
  output logic                      running,
  output logic                      warn,
  output logic                      expired,
  output logic                      time_up,
  output logic                      load_err
);

  localparam int              CW       = 4 * NUM_DIGITS;
  localparam logic [CW-1:0]   CNT_ZERO = '0;
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   count_dec;
  logic [CW-1:0]   count_next;
  logic [NUM_DIGITS:0] borrow;
  logic            underflow;
  logic            load_ok;
  logic            start_go;
  logic            pause_go;
  logic            expired_next;
  logic            load_err_next;
  logic            running_next;
  logic            warn_next;
  logic            time_up_next;

  // Decrement chain: digit 0 always takes the decrement.
  assign borrow[0] = 1'b1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit_dec u_dec (
      .digit      (count[4*g +: 4]),
      .borrow_in  (borrow[g]),
      .digit_next (count_dec[4*g +: 4]),
      .borrow_out (borrow[g+1])
    );
  end

  // A borrow out of the top digit means the count was already zero.
  assign underflow = borrow[NUM_DIGITS];

  // Accept a load only when every nibble is a legal BCD digit.
  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!digit_ok(load_value[4*i +: 4])) load_ok = 1'b0;
    end
  end

  // Start/pause only count as transitions when they actually change state;
  // start and pause together cancel each other.
  assign start_go = start && !pause && (state == IDLE || state == PAUSED) && (count != CNT_ZERO);
  assign pause_go = pause && !start && (state == RUN);

  // Next state and count: load > start/pause > tick.
  always_comb begin
    state_next    = state;
    count_next    = count;
    expired_next  = 1'b0;
    load_err_next = 1'b0;
    if (load) begin
      if (load_ok) begin
        count_next = load_value;
        state_next = IDLE;
      end else begin
        load_err_next = 1'b1;
      end
    end else if (start_go) begin
      state_next = RUN;
    end else if (pause_go) begin
      state_next = PAUSED;
    end else if (tick && state == RUN && !underflow) begin
      count_next = count_dec;
      if (count == CNT_ONE) begin
        state_next   = DONE;
        expired_next = 1'b1;
      end
    end
  end

  // Status outputs derived from the next state so they register alongside it.
  always_comb begin
    running_next = (state_next == RUN);
    warn_next    = running_next && (count_next <= WARN_BCD);
    time_up_next = (state_next == DONE);
  end

  // State, count and all outputs registered; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state    <= IDLE;
      count    <= CNT_ZERO;
      running  <= 1'b0;
      warn     <= 1'b0;
      expired  <= 1'b0;
      time_up  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      running  <= running_next;
      warn     <= warn_next;
      expired  <= expired_next;
      time_up  <= time_up_next;
      load_err <= load_err_next;
    end
  end

endmodule

// File: tb/tb_countdown_bcd_timer.sv
// Self-checking bench for countdown_bcd_timer: an integer-valued model is
// compared with the DUT on every cycle, with directed literal checks on top.
module tb_countdown_bcd_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_value = 16'h0000;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [15:0] count;
  logic        running, warn, expired, time_up, load_err;

  int checks = 0;
  int fails  = 0;

  countdown_bcd_timer #(.NUM_DIGITS(4), .WARN_BCD(16'h0010)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .pause      (pause),
    .count      (count),
    .running    (running),
    .warn       (warn),
    .expired    (expired),
    .time_up    (time_up),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (decimal integer) ----------------
  typedef enum int {M_IDLE, M_RUN, M_PAUSED, M_DONE} mode_t;

  function automatic bit bcd_valid(input logic [15:0] b);
    for (int i = 0; i < 4; i++) if (((b >> (4*i)) & 16'hF) > 9) return 0;
    return 1;
  endfunction

  function automatic int bcd2int(input logic [15:0] b);
    int v = 0;
    int m = 1;
    for (int i = 0; i < 4; i++) begin
      v += int'((b >> (4*i)) & 16'hF) * m;
      m *= 10;
    end
    return v;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] b = '0;
    int m = 1;
    for (int i = 0; i < 4; i++) begin
      b |= 16'((v / m) % 10) << (4*i);
      m *= 10;
    end
    return b;
  endfunction

  mode_t m_mode = M_IDLE;
  int    m_val = 0;
  bit    m_expired = 0;
  bit    m_load_err = 0;
  bit    m_valid = 0;

  always @(posedge clk) begin
    m_expired  = 0;
    m_load_err = 0;
    if (reset) begin
      m_mode  = M_IDLE;
      m_val   = 0;
      m_valid = 1;
    end else if (load) begin
      if (bcd_valid(load_value)) begin
        m_val  = bcd2int(load_value);
        m_mode = M_IDLE;
      end else begin
        m_load_err = 1;
      end
    end else if (start && !pause && (m_mode == M_IDLE || m_mode == M_PAUSED) && m_val != 0) begin
      m_mode = M_RUN;
    end else if (pause && !start && m_mode == M_RUN) begin
      m_mode = M_PAUSED;
    end else if (tick && m_mode == M_RUN) begin
      m_val = m_val - 1;
      if (m_val == 0) begin
        m_mode    = M_DONE;
        m_expired = 1;
      end
    end
  end

  // Compare every cycle once the model has seen reset.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_count",    32'(count),    32'(int2bcd(m_val)));
      check("model_running",  32'(running),  32'(m_mode == M_RUN));
      check("model_warn",     32'(warn),     32'(m_mode == M_RUN && m_val <= 10));
      check("model_expired",  32'(expired),  32'(m_expired));
      check("model_time_up",  32'(time_up),  32'(m_mode == M_DONE));
      check("model_load_err", 32'(load_err), 32'(m_load_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit rst, input bit ld, input logic [15:0] lv,
                       input bit st, input bit pa, input bit tk);
    reset = rst; load = ld; load_value = lv; start = st; pause = pa; tick = tk;
    @(posedge clk);
    #1;
    reset = 0; load = 0; start = 0; pause = 0; tick = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 16'h0000, 0, 0, 0);
  endtask

  task automatic do_tick(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 16'h0000, 0, 0, 1);
  endtask

  task automatic do_load(input logic [15:0] lv);
    drive(0, 1, lv, 0, 0, 0);
  endtask

  task automatic do_start();
    drive(0, 0, 16'h0000, 1, 0, 0);
  endtask

  initial begin
    drive(1, 0, 16'h0000, 0, 0, 0);
    drive(1, 0, 16'h0000, 0, 0, 0);
    check("reset_count", 32'(count), 32'h0);
    check("reset_running", 32'(running), 0);
    check("reset_time_up", 32'(time_up), 0);

    // Basic countdown to expiry.
    do_load(16'h0003);
    check("load3_count", 32'(count), 32'h0003);
    do_start();
    check("start_running", 32'(running), 1);
    do_tick(1);
    check("tick_0002", 32'(count), 32'h0002);
    do_tick(1);
    check("tick_0001", 32'(count), 32'h0001);
    do_tick(1);
    check("tick_0000", 32'(count), 32'h0000);
    check("expired_pulse", 32'(expired), 1);
    check("time_up_set", 32'(time_up), 1);
    check("done_not_running", 32'(running), 0);
    idle(1);
    check("expired_clear", 32'(expired), 0);
    check("time_up_hold", 32'(time_up), 1);

    // Borrow across digits and warn threshold.
    do_load(16'h0100);
    do_start();
    do_tick(1);
    check("borrow_0099", 32'(count), 32'h0099);
    check("warn_off_99", 32'(warn), 0);
    do_tick(88);
    check("count_0011", 32'(count), 32'h0011);
    check("warn_off_11", 32'(warn), 0);
    do_tick(1);
    check("count_0010", 32'(count), 32'h0010);
    check("warn_on_10", 32'(warn), 1);

    // Rejected load leaves count and state alone.
    do_load(16'h00A5);
    check("load_err_pulse", 32'(load_err), 1);
    check("bad_load_count", 32'(count), 32'h0010);
    check("bad_load_running", 32'(running), 1);
    idle(1);
    check("load_err_clear", 32'(load_err), 0);

    // Pause holds the count, resume finishes.
    do_load(16'h0005);
    do_start();
    do_tick(1);
    check("pause_pre_0004", 32'(count), 32'h0004);
    drive(0, 0, 16'h0000, 0, 1, 0);
    check("paused_running", 32'(running), 0);
    do_tick(4);
    check("paused_hold", 32'(count), 32'h0004);
    do_start();
    do_tick(4);
    check("resume_0000", 32'(count), 32'h0000);
    check("resume_expired", 32'(expired), 1);
    idle(1);
    check("resume_single_pulse", 32'(expired), 0);

    // Ticks dropped on transition cycles; start+pause cancel.
    drive(0, 1, 16'h0007, 0, 0, 1);
    check("load_tick_count", 32'(count), 32'h0007);
    drive(0, 0, 16'h0000, 1, 0, 1);
    check("start_tick_count", 32'(count), 32'h0007);
    check("start_tick_running", 32'(running), 1);
    do_load(16'h0007);
    drive(0, 0, 16'h0000, 1, 1, 0);
    check("start_pause_idle", 32'(running), 0);
    do_start();
    check("start_after_cancel", 32'(running), 1);

    // Reset mid-count with tick: no expiry.
    do_load(16'h0002);
    do_start();
    drive(1, 0, 16'h0000, 0, 0, 1);
    check("rst_count", 32'(count), 32'h0000);
    check("rst_running", 32'(running), 0);
    check("rst_expired", 32'(expired), 0);
    check("rst_time_up", 32'(time_up), 0);

    // Ticks in DONE ignored; start in DONE ignored.
    do_load(16'h0001);
    do_start();
    do_tick(1);
    check("done_entry", 32'(time_up), 1);
    do_tick(3);
    check("done_hold_count", 32'(count), 32'h0000);
    check("done_no_expired", 32'(expired), 0);
    do_start();
    check("done_start_ignored", 32'(running), 0);

    // Randomized phase, checked by the model every cycle.
    for (int n = 0; n < 4000; n++) begin
      bit rst = ($urandom_range(0, 299) == 0);
      bit ld  = ($urandom_range(0, 24) == 0);
      logic [15:0] lv;
      case ($urandom_range(0, 3))
        0:       lv = 16'($urandom);
        1:       lv = int2bcd($urandom_range(0, 9999));
        default: lv = int2bcd($urandom_range(0, 30));
      endcase
      drive(rst, ld, lv, $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 1) == 1);
    end

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
